fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the Core101 pipeline.
- Owns the program counter and issues word fetches over a request/acknowledge memory port.
- Presents the fetched instruction and its PC, plus a one-cycle load strobe, to the downstream IF/ID pipeline register. That register is a negedge, set-enabled register.
- Handles downstream stalls and branch/jump redirects, including redirects that arrive while a request is still outstanding.

Parameters:
- DATA_WIDTH, 32: width of PC, address and instruction.
- RESET_PC, 0: PC value loaded on reset. Bits [1:0] are ignored and treated as 0.

Ports:
- clock_in  input  1  single clock; all state updates on posedge
- reset_in  input  1  synchronous active-high reset
- stall_in  input  1  downstream cannot accept an instruction this cycle
- branch_valid_in  input  1  redirect request, single-cycle
- branch_target_in  input  DATA_WIDTH  redirect target address
- mem_req_out  output  1  fetch request
- mem_addr_out  output  DATA_WIDTH  fetch address, word aligned
- mem_ack_in  input  1  memory returns data this cycle
- mem_data_in  input  DATA_WIDTH  fetched instruction, valid when mem_ack_in=1
- inst_out  output  DATA_WIDTH  captured instruction
- pc_out  output  DATA_WIDTH  PC of inst_out
- inst_set_out  output  1  load strobe; drives set_in of the IF/ID register

Behaviour:
- Reset: reset_in sampled at posedge.
  - pc <= RESET_PC & ~3; state <= FETCH.
  - inst_out, pc_out, mem_addr_out <= 0; mem_req_out = 0; inst_set_out = 0.
  - Reset overrides every other input, including a mid-request ack (the ack is ignored).
- Registers: pc (next address) and req_addr (address of the outstanding request). mem_addr_out = req_addr.
- Request rule: once mem_req_out=1, it stays 1 and mem_addr_out stays stable until the cycle mem_ack_in=1. A request is never abandoned.
- Alignment: branch_target_in[1:0] is forced to 00 on capture. PC increments by 4 modulo 2^DATA_WIDTH, so wrap-around is silent.
- FSM states: FETCH, DELIVER, FLUSH.
- FETCH:
  - mem_req_out=1; req_addr=pc, latched on entry.
  - ack=1 and branch_valid_in=0: inst_out <= mem_data_in, pc_out <= req_addr, go to DELIVER.
  - ack=1 and branch_valid_in=1: discard data, pc <= target, stay FETCH (new request next cycle).
  - ack=0 and branch_valid_in=1: pc <= target, go to FLUSH.
  - ack=0 and branch_valid_in=0: wait in FETCH.
- DELIVER:
  - mem_req_out=0; inst_set_out = !stall_in && !branch_valid_in (combinational).
  - branch_valid_in=1: squash (inst_set_out=0), pc <= target, go to FETCH.
  - stall_in=1: hold; inst_out and pc_out unchanged.
  - Otherwise: pc <= pc+4, go to FETCH.
  - The downstream negedge register captures inst_out/pc_out mid-cycle in the strobe cycle.
- FLUSH:
  - mem_req_out=1 with old req_addr.
  - ack=1: discard data, go to FETCH (new request from pc).
  - branch_valid_in=1 in FLUSH: pc <= newest target; if ack is also 1, go to FETCH.
- Priority: reset > branch_valid_in > mem_ack_in > stall_in.
- Throughput: zero-wait memory (ack in the request cycle) gives 1 instruction per 2 cycles. Each wait state adds 1 cycle.
- inst_set_out is never asserted in FETCH or FLUSH; at most one pulse per fetched instruction.

Decomposition:
- Shared package core101_fetch_pkg:
  - state encoding FETCH=2'd0, DELIVER=2'd1, FLUSH=2'd2;
  - constant PC_INCREMENT=4;
  - constant ALIGN_MASK.
- One natural sub-module, fetch_pc_gen: combinational next-pc mux (reset / target / pc+4 / hold) with alignment.
- FSM and output registers stay in fetch_unit.

Test Plan:
- Reset, RESET_PC=0x100: after release, mem_req_out=1, mem_addr_out=0x100 in the first cycle. Reset asserted mid-request drives mem_req_out=0 and inst_out=0 next cycle.
- Zero-wait memory returning 0x00000013 at every address, no stall: strobes every 2nd cycle with pc_out 0x100, 0x104, 0x108; 1 pulse each.
- ack delayed 3 cycles at 0x104: mem_addr_out held at 0x104 for 4 cycles with mem_req_out=1; single strobe with pc_out=0x104.
- stall_in=1 for 5 cycles in DELIVER: inst_set_out=0, inst_out/pc_out stable, no new request. One strobe on release, then fetch of pc+4.
- Branch to 0x203 one cycle after a request to 0x108, with ack 2 cycles later: FLUSH, data discarded, no strobe for 0x108. Next request at 0x200; strobe pc_out=0x200.
- DATA_WIDTH=32, pc=0xFFFFFFFC, no stall: next request at 0x00000000.

Source files
------------

// File: rtl/core101_fetch_pkg.sv
// core101_fetch_pkg: shared state encoding and address constants for the Core101 fetch stage
package core101_fetch_pkg;
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        FLUSH   = 2'd2
    } fetch_state_e;
    localparam int PC_INCREMENT = 4;
    localparam int ALIGN_MASK   = 3;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-pc select (reset / redirect / advance / hold) with word alignment
module fetch_pc_gen
    import core101_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  reset_in,
    input  logic                  branch_valid_in,
    input  logic [DATA_WIDTH-1:0] branch_target_in,
    input  logic                  advance_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic [DATA_WIDTH-1:0] next_pc
);
    localparam logic [DATA_WIDTH-1:0] MASK = ~DATA_WIDTH'(ALIGN_MASK);
    localparam logic [DATA_WIDTH-1:0] INC  = DATA_WIDTH'(PC_INCREMENT);
    always_comb begin
        next_pc = reset_in        ? (RESET_PC & MASK) :
                  branch_valid_in ? (branch_target_in & MASK) :
                  advance_in      ? pc_in + INC : pc_in;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: Core101 instruction fetch; owns the pc, runs the memory request handshake
// and strobes fetched instructions into the negedge IF/ID register.
module fetch_unit
    import core101_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  stall_in,
    input  logic                  branch_valid_in,
    input  logic [DATA_WIDTH-1:0] branch_target_in,
    output logic                  mem_req_out,
    output logic [DATA_WIDTH-1:0] mem_addr_out,
    input  logic                  mem_ack_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  inst_set_out
);
    fetch_state_e          state, next_state;
    logic [DATA_WIDTH-1:0] pc, next_pc, req_addr;
    logic                  advance, capture;
    fetch_pc_gen #(.DATA_WIDTH(DATA_WIDTH), .RESET_PC(RESET_PC)) u_pc_gen (
        .reset_in        (reset_in),
        .branch_valid_in (branch_valid_in),
        .branch_target_in(branch_target_in),
        .advance_in      (advance),
        .pc_in           (pc),
        .next_pc         (next_pc)
    );
    // While in FETCH the request address is the live pc; FLUSH keeps the one latched on the way out
    always_comb begin
        advance      = state == DELIVER && !stall_in && !branch_valid_in;
        capture      = state == FETCH && mem_ack_in && !branch_valid_in;
        inst_set_out = !reset_in && advance;
        mem_req_out  = !reset_in && state != DELIVER;
        mem_addr_out = reset_in ? '0 : state == FETCH ? pc : req_addr;
        next_state   = state == FETCH   ? (branch_valid_in ? (mem_ack_in ? FETCH : FLUSH) :
                                                             (mem_ack_in ? DELIVER : FETCH)) :
                       state == DELIVER ? ((branch_valid_in || !stall_in) ? FETCH : DELIVER) :
                                          (mem_ack_in ? FETCH : FLUSH);
    end
    always_ff @(posedge clock_in) begin
        pc <= next_pc;
        if (reset_in) begin
            state    <= FETCH;
            req_addr <= '0;
            inst_out <= '0;
            pc_out   <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH) req_addr <= pc;
            if (capture) begin
                inst_out <= mem_data_in;
                pc_out   <= pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of reset, handshake, stall, redirect and wrap behaviour
module tb_fetch_unit;
    logic        clk = 0, rst, stall, br_v, ack, req, set;
    logic [31:0] br_t, data, addr, inst, pco;
    int          checks = 0, errors = 0;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h100)) dut (
        .clock_in(clk), .reset_in(rst), .stall_in(stall),
        .branch_valid_in(br_v), .branch_target_in(br_t),
        .mem_req_out(req), .mem_addr_out(addr),
        .mem_ack_in(ack), .mem_data_in(data),
        .inst_out(inst), .pc_out(pco), .inst_set_out(set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; br_v = 0; br_t = 0; ack = 0; data = 0;
        step(); step();
        #1;
        chk("rst_req", {31'b0, req}, 1'b0);
        chk("rst_addr", addr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", pco, 0);
        chk("rst_set", {31'b0, set}, 1'b0);
        rst = 0; #1;
        chk("first_req", {31'b0, req}, 1'b1);
        chk("first_addr", addr, 32'h100);
        chk("first_set", {31'b0, set}, 1'b0);
        ack = 1; data = 32'h13; step();
        ack = 0; #1;
        chk("zw_set", {31'b0, set}, 1'b1);
        chk("zw_inst", inst, 32'h13);
        chk("zw_pc", pco, 32'h100);
        chk("zw_req", {31'b0, req}, 1'b0);
        step(); #1;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'b0, req}, 1'b1);
            chk("wait_addr", addr, 32'h104);
            chk("wait_set", {31'b0, set}, 1'b0);
            step(); #1;
        end
        ack = 1; data = 32'h00A00093; #1;
        chk("ack_addr", addr, 32'h104);
        step();
        ack = 0; stall = 1; #1;
        chk("stall_set0", {31'b0, set}, 1'b0);
        chk("stall_req0", {31'b0, req}, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("stall_set", {31'b0, set}, 1'b0);
            chk("stall_req", {31'b0, req}, 1'b0);
            chk("stall_inst", inst, 32'h00A00093);
            chk("stall_pc", pco, 32'h104);
        end
        step();
        stall = 0; #1;
        chk("rel_set", {31'b0, set}, 1'b1);
        chk("rel_pc", pco, 32'h104);
        step(); #1;
        chk("next_addr", addr, 32'h108);
        chk("next_req", {31'b0, req}, 1'b1);
        step();
        br_v = 1; br_t = 32'h203; #1;
        chk("br_set", {31'b0, set}, 1'b0);
        step();
        br_v = 0; #1;
        chk("flush_req", {31'b0, req}, 1'b1);
        chk("flush_addr", addr, 32'h108);
        step();
        ack = 1; data = 32'hDEADBEEF; #1;
        chk("flush_addr2", addr, 32'h108);
        chk("flush_set", {31'b0, set}, 1'b0);
        step();
        ack = 0; #1;
        chk("redir_req", {31'b0, req}, 1'b1);
        chk("redir_addr", addr, 32'h200);
        chk("redir_set", {31'b0, set}, 1'b0);
        chk("discard_inst", inst, 32'h00A00093);
        ack = 1; data = 32'h13; step();
        ack = 0; #1;
        chk("redir_strobe", {31'b0, set}, 1'b1);
        chk("redir_pc", pco, 32'h200);
        step();
        ack = 1; data = 32'h11; br_v = 1; br_t = 32'hFFFFFFFE; step();
        ack = 0; br_v = 0; #1;
        chk("wrap_addr", addr, 32'hFFFFFFFC);
        chk("wrap_set", {31'b0, set}, 1'b0);
        chk("ackbr_inst", inst, 32'h13);
        ack = 1; data = 32'h33; step();
        ack = 0; #1;
        chk("wrap_strobe", {31'b0, set}, 1'b1);
        chk("wrap_pc", pco, 32'hFFFFFFFC);
        step(); #1;
        chk("wrap_next", addr, 32'h0);
        chk("wrap_req", {31'b0, req}, 1'b1);
        ack = 1; data = 32'h55; step();
        ack = 0; br_v = 1; br_t = 32'h300; #1;
        chk("squash_set", {31'b0, set}, 1'b0);
        step();
        br_v = 0; #1;
        chk("squash_addr", addr, 32'h300);
        chk("squash_req", {31'b0, req}, 1'b1);
        ack = 1; data = 32'h77; rst = 1; step();
        #1;
        chk("midrst_req", {31'b0, req}, 1'b0);
        chk("midrst_inst", inst, 0);
        chk("midrst_pc", pco, 0);
        rst = 0; ack = 0; #1;
        chk("postrst_req", {31'b0, req}, 1'b1);
        chk("postrst_addr", addr, 32'h100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
